// File: rtl/reg_file_pkg.sv
// Shared definitions for the register-file access controller.
package reg_file_pkg;

   localparam int DEF_LEVEL_BITS = 4;
   localparam int DEF_BYTE_BITS  = 4;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ACC0 = 3'd1,
      ST_ACC1 = 3'd2,
      ST_WAIT = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   // Requester ids; also the index into the arbiter's req/grant vectors
   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/reg_file_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter. On a tie, the port not granted last wins.
module rr_arbiter2
   import reg_file_pkg::*;
(
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic [1:0] i_req,
   input  logic       i_advance,
   output logic [1:0] o_grant
);

   logic r_last_b;

   // One-hot grant from current requests and grant history
   always_comb begin
      o_grant = 2'b00;
      case (i_req)
         2'b01:   o_grant = 2'b01;
         2'b10:   o_grant = 2'b10;
         2'b11:   o_grant = r_last_b ? 2'b01 : 2'b10;
         default: o_grant = 2'b00;
      endcase
   end

   // Remember who was granted; history starts at B so A wins the first tie
   always_ff @(posedge i_clock) begin
      if (i_reset)
         r_last_b <= PORT_B;
      else if (i_advance && (|o_grant))
         r_last_b <= o_grant[1];
   end

endmodule

// File: rtl/reg_file_ctrl.sv
// Sequences byte/word register accesses from two requesters onto a 256x8
// sync RAM (read data one cycle after address). Banks are selected by level.
//
//  state | meaning
//  IDLE  | arbitrate, latch winner's command
//  ACC0  | drive byte / high-byte address (and write data)
//  ACC1  | drive low-byte address; capture high read byte
//  WAIT  | capture last read byte into rdata
//  DONE  | done pulse to the granted port
module reg_file_ctrl
   import reg_file_pkg::*;
#(
   parameter int LEVEL_BITS = DEF_LEVEL_BITS,
   parameter int BYTE_BITS  = DEF_BYTE_BITS
)(
   input  logic                            i_clock,
   input  logic                            i_reset,
   input  logic                            i_a_req,
   input  logic                            i_a_we,
   input  logic                            i_a_word,
   input  logic [LEVEL_BITS-1:0]           i_a_level,
   input  logic [BYTE_BITS-1:0]            i_a_reg,
   input  logic [15:0]                     i_a_wdata,
   output logic                            o_a_done,
   input  logic                            i_b_req,
   input  logic                            i_b_we,
   input  logic                            i_b_word,
   input  logic [LEVEL_BITS-1:0]           i_b_level,
   input  logic [BYTE_BITS-1:0]            i_b_reg,
   input  logic [15:0]                     i_b_wdata,
   output logic                            o_b_done,
   output logic [15:0]                     o_rdata,
   output logic [LEVEL_BITS+BYTE_BITS-1:0] o_ram_addr,
   output logic                            o_ram_we,
   output logic [7:0]                      o_ram_wdata,
   input  logic [7:0]                      i_ram_rdata
);

   localparam int AW = LEVEL_BITS + BYTE_BITS;

   state_t                r_state;
   logic                  r_port;
   logic                  r_we;
   logic                  r_word;
   logic [LEVEL_BITS-1:0] r_level;
   logic [BYTE_BITS-1:0]  r_reg;
   logic [15:0]           r_wdata;
   logic [7:0]            r_hi;
   logic [15:0]           r_rdata;
   logic                  r_a_done;
   logic                  r_b_done;

   logic [1:0]            w_grant;
   logic                  w_advance;
   logic [AW-1:0]         w_byte_addr;
   logic [AW-1:0]         w_hi_addr;
   logic [AW-1:0]         w_lo_addr;

   assign w_advance   = (r_state == ST_IDLE);
   assign w_byte_addr = {r_level, r_reg};
   assign w_hi_addr   = {r_level, r_reg[BYTE_BITS-1:1], 1'b0};
   assign w_lo_addr   = {r_level, r_reg[BYTE_BITS-1:1], 1'b1};

   assign o_a_done = r_a_done;
   assign o_b_done = r_b_done;
   assign o_rdata  = r_rdata;

   rr_arbiter2 u_arb (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_req     ({i_b_req, i_a_req}),
      .i_advance (w_advance),
      .o_grant   (w_grant)
   );

   // Access sequencer: latches the granted command and steps through RAM cycles
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state  <= ST_IDLE;
         r_port   <= PORT_A;
         r_we     <= 1'b0;
         r_word   <= 1'b0;
         r_level  <= '0;
         r_reg    <= '0;
         r_wdata  <= '0;
         r_hi     <= '0;
         r_rdata  <= '0;
         r_a_done <= 1'b0;
         r_b_done <= 1'b0;
      end else begin
         r_a_done <= 1'b0;
         r_b_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (|w_grant) begin
                  r_port  <= w_grant[1];
                  r_we    <= w_grant[1] ? i_b_we    : i_a_we;
                  r_word  <= w_grant[1] ? i_b_word  : i_a_word;
                  r_level <= w_grant[1] ? i_b_level : i_a_level;
                  r_reg   <= w_grant[1] ? i_b_reg   : i_a_reg;
                  r_wdata <= w_grant[1] ? i_b_wdata : i_a_wdata;
                  r_state <= ST_ACC0;
               end
            end
            ST_ACC0: begin
               if (r_word) begin
                  r_state <= ST_ACC1;
               end else if (r_we) begin
                  r_state  <= ST_DONE;
                  r_a_done <= (r_port == PORT_A);
                  r_b_done <= (r_port == PORT_B);
               end else begin
                  r_state <= ST_WAIT;
               end
            end
            ST_ACC1: begin
               // High byte is staged so rdata only changes when a read completes
               if (!r_we)
                  r_hi <= i_ram_rdata;
               if (r_we) begin
                  r_state  <= ST_DONE;
                  r_a_done <= (r_port == PORT_A);
                  r_b_done <= (r_port == PORT_B);
               end else begin
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               r_rdata  <= r_word ? {r_hi, i_ram_rdata} : {8'h00, i_ram_rdata};
               r_state  <= ST_DONE;
               r_a_done <= (r_port == PORT_A);
               r_b_done <= (r_port == PORT_B);
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // RAM strobes decoded from state; write is blocked in a reset cycle so an
   // aborted word write leaves the low byte untouched
   always_comb begin
      o_ram_addr  = '0;
      o_ram_we    = 1'b0;
      o_ram_wdata = 8'h00;
      case (r_state)
         ST_ACC0: begin
            o_ram_addr  = r_word ? w_hi_addr : w_byte_addr;
            o_ram_we    = r_we;
            o_ram_wdata = r_word ? r_wdata[15:8] : r_wdata[7:0];
         end
         ST_ACC1: begin
            o_ram_addr  = w_lo_addr;
            o_ram_we    = r_we;
            o_ram_wdata = r_wdata[7:0];
         end
         default: ;
      endcase
      if (i_reset)
         o_ram_we = 1'b0;
   end

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Bench for reg_file_ctrl with a behavioural 256x8 sync RAM.
module tb_reg_file_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_req = 1'b0, a_we = 1'b0, a_word = 1'b0;
   logic [3:0]  a_level = '0, a_reg = '0;
   logic [15:0] a_wdata = '0;
   logic        a_done;
   logic        b_req = 1'b0, b_we = 1'b0, b_word = 1'b0;
   logic [3:0]  b_level = '0, b_reg = '0;
   logic [15:0] b_wdata = '0;
   logic        b_done;
   logic [15:0] rdata;
   logic [7:0]  ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata = '0;
   logic [7:0]  mem [256];

   int n_vec = 0, n_err = 0;
   int cyc = 0;
   int exp_a = 0, exp_b = 0;
   int a_cnt = 0, b_cnt = 0, both_cnt = 0;

   reg_file_ctrl dut (
      .i_clock     (clk),
      .i_reset     (rst),
      .i_a_req     (a_req),
      .i_a_we      (a_we),
      .i_a_word    (a_word),
      .i_a_level   (a_level),
      .i_a_reg     (a_reg),
      .i_a_wdata   (a_wdata),
      .o_a_done    (a_done),
      .i_b_req     (b_req),
      .i_b_we      (b_we),
      .i_b_word    (b_word),
      .i_b_level   (b_level),
      .i_b_reg     (b_reg),
      .i_b_wdata   (b_wdata),
      .o_b_done    (b_done),
      .o_rdata     (rdata),
      .o_ram_addr  (ram_addr),
      .o_ram_we    (ram_we),
      .o_ram_wdata (ram_wdata),
      .i_ram_rdata (ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // RegisterRAM: sync write, registered read
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   always @(negedge clk) begin
      if (a_done) a_cnt = a_cnt + 1;
      if (b_done) b_cnt = b_cnt + 1;
      if (a_done && b_done) both_cnt = both_cnt + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One access from an idle controller; lat counts cycles from accept to done
   task automatic do_access(input logic port, input logic we, input logic word,
                            input logic [3:0] lvl, input logic [3:0] rg,
                            input logic [15:0] wd, output int lat,
                            output logic [15:0] rd, output logic wrong);
      int t0;
      @(negedge clk);
      if (port == 1'b0) begin
         a_we = we; a_word = word; a_level = lvl; a_reg = rg; a_wdata = wd; a_req = 1'b1;
         exp_a++;
      end else begin
         b_we = we; b_word = word; b_level = lvl; b_reg = rg; b_wdata = wd; b_req = 1'b1;
         exp_b++;
      end
      t0 = cyc; lat = -1; rd = '0; wrong = 1'b0;
      for (int k = 0; k < 12 && lat < 0; k++) begin
         @(negedge clk);
         if ((port == 1'b0 && b_done) || (port == 1'b1 && a_done)) wrong = 1'b1;
         if ((port == 1'b0 && a_done) || (port == 1'b1 && b_done)) begin
            lat = cyc - t0;
            rd  = rdata;
         end
      end
      a_req = 1'b0;
      b_req = 1'b0;
   endtask

   typedef struct {
      logic        port;
      logic        we;
      logic        word;
      logic [3:0]  lvl;
      logic [3:0]  rg;
      logic [15:0] wd;
      int          lat;
      logic [15:0] rd;
      logic [7:0]  addr;
      logic [7:0]  e0;
      logic [7:0]  e1;
   } vec_t;

   vec_t vecs [11];

   initial begin
      int          lat, t0, t1, n, na, nb, ia, ib;
      logic [15:0] rd;
      logic        wrong;
      int          order [8];
      int          exp_order [8];

      // port, we, word, lvl, reg, wdata, lat, rdata at done, write addr, bytes
      vecs[0]  = '{1'b0, 1'b1, 1'b1, 4'h3, 4'h4, 16'hBEEF, 3, 16'h0000, 8'h34, 8'hBE, 8'hEF};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 4'h3, 4'h4, 16'h0000, 4, 16'hBEEF, 8'h00, 8'h00, 8'h00};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 4'hF, 4'hF, 16'hFF5A, 2, 16'hBEEF, 8'hFF, 8'h5A, 8'h00};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 16'h0000, 3, 16'h005A, 8'h00, 8'h00, 8'h00};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 4'h7, 4'h4, 16'h1234, 3, 16'h005A, 8'h74, 8'h12, 8'h34};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 4'h7, 4'h5, 16'h0000, 4, 16'h1234, 8'h00, 8'h00, 8'h00};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 4'h7, 4'h5, 16'h0000, 3, 16'h0034, 8'h00, 8'h00, 8'h00};
      vecs[7]  = '{1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 16'hC3A7, 3, 16'h0034, 8'h00, 8'hC3, 8'hA7};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 4'h0, 4'h1, 16'h0000, 4, 16'hC3A7, 8'h00, 8'h00, 8'h00};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 4'h3, 4'h6, 16'hCAFE, 3, 16'hC3A7, 8'h36, 8'hCA, 8'hFE};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 4'h3, 4'h7, 16'h0000, 3, 16'h00FE, 8'h00, 8'h00, 8'h00};

      exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_a_done", {31'd0, a_done}, 32'd0);
      chk("rst_b_done", {31'd0, b_done}, 32'd0);
      chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
      chk("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
      chk("rst_rdata", {16'd0, rdata}, 32'd0);
      rst = 1'b0;

      // Table of single accesses
      for (int i = 0; i < 11; i++) begin
         do_access(vecs[i].port, vecs[i].we, vecs[i].word, vecs[i].lvl, vecs[i].rg,
                   vecs[i].wd, lat, rd, wrong);
         chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         chk($sformatf("v%0d_rdata", i), {16'd0, rd}, {16'd0, vecs[i].rd});
         chk($sformatf("v%0d_other_done", i), {31'd0, wrong}, 32'd0);
         if (vecs[i].we) begin
            chk($sformatf("v%0d_mem_hi", i), {24'd0, mem[vecs[i].addr]}, {24'd0, vecs[i].e0});
            if (vecs[i].word)
               chk($sformatf("v%0d_mem_lo", i), {24'd0, mem[vecs[i].addr + 8'd1]},
                   {24'd0, vecs[i].e1});
         end
      end

      // Reset during ACC1 of a word write: hi byte lands, lo byte and done do not
      do_access(1'b0, 1'b1, 1'b0, 4'h2, 4'h7, 16'h0055, lat, rd, wrong);
      chk("prewrite_latency", lat, 2);
      @(negedge clk);
      a_we = 1'b1; a_word = 1'b1; a_level = 4'h2; a_reg = 4'h6; a_wdata = 16'hA1B2; a_req = 1'b1;
      @(negedge clk);
      chk("rstseq_acc0_addr", {24'd0, ram_addr}, 32'h26);
      chk("rstseq_acc0_wdata", {24'd0, ram_wdata}, 32'hA1);
      a_req = 1'b0;
      @(negedge clk);
      chk("rstseq_acc1_addr", {24'd0, ram_addr}, 32'h27);
      rst = 1'b1;
      #1;
      chk("rstseq_we_gated", {31'd0, ram_we}, 32'd0);
      @(negedge clk);
      chk("rstseq_idle_we", {31'd0, ram_we}, 32'd0);
      chk("rstseq_idle_addr", {24'd0, ram_addr}, 32'd0);
      chk("rstseq_rdata", {16'd0, rdata}, 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("rstseq_mem_hi", {24'd0, mem[8'h26]}, 32'hA1);
      chk("rstseq_mem_lo", {24'd0, mem[8'h27]}, 32'h55);

      // Simultaneous requests, 4 each, held until served: expect A,B,A,B,...
      @(negedge clk);
      a_we = 1'b1; a_word = 1'b0; a_level = 4'h4; a_reg = 4'h0; a_wdata = 16'h00A0; a_req = 1'b1;
      b_we = 1'b1; b_word = 1'b0; b_level = 4'h5; b_reg = 4'h0; b_wdata = 16'h00B0; b_req = 1'b1;
      exp_a += 4; exp_b += 4;
      n = 0; na = 4; nb = 4;
      for (int k = 0; k < 80 && (na > 0 || nb > 0); k++) begin
         @(negedge clk);
         if (a_done && na > 0) begin
            if (n < 8) order[n] = 0;
            n++; na--;
            ia = 4 - na;
            if (na == 0) a_req = 1'b0;
            else begin a_reg = ia[3:0]; a_wdata = 16'h00A0 + 16'(ia); end
         end
         if (b_done && nb > 0) begin
            if (n < 8) order[n] = 1;
            n++; nb--;
            ib = 4 - nb;
            if (nb == 0) b_req = 1'b0;
            else begin b_reg = ib[3:0]; b_wdata = 16'h00B0 + 16'(ib); end
         end
      end
      a_req = 1'b0; b_req = 1'b0;
      chk("tie_count", n, 8);
      for (int j = 0; j < 8; j++)
         chk($sformatf("tie_order_%0d", j), order[j], exp_order[j]);
      chk("tie_mem_a3", {24'd0, mem[8'h43]}, 32'hA3);
      chk("tie_mem_b0", {24'd0, mem[8'h50]}, 32'hB0);

      // Held req with changing inputs after accept; back-to-back byte writes
      @(negedge clk);
      a_we = 1'b1; a_word = 1'b0; a_level = 4'h1; a_reg = 4'h0; a_wdata = 16'h0011; a_req = 1'b1;
      exp_a += 2;
      t0 = cyc;
      @(negedge clk);
      a_wdata = 16'h0099; a_reg = 4'h3;
      #1;
      chk("b2b_acc0_addr", {24'd0, ram_addr}, 32'h10);
      chk("b2b_acc0_wdata", {24'd0, ram_wdata}, 32'h11);
      @(negedge clk);
      chk("b2b_done1", {31'd0, a_done}, 32'd1);
      chk("b2b_lat1", cyc - t0, 2);
      a_reg = 4'h1; a_wdata = 16'h0022;
      t1 = cyc;
      @(negedge clk);
      chk("b2b_idle_we", {31'd0, ram_we}, 32'd0);
      chk("b2b_idle_done", {31'd0, a_done}, 32'd0);
      @(negedge clk);
      chk("b2b_acc0b_addr", {24'd0, ram_addr}, 32'h11);
      chk("b2b_acc0b_we", {31'd0, ram_we}, 32'd1);
      a_wdata = 16'h0077;
      @(negedge clk);
      chk("b2b_done2", {31'd0, a_done}, 32'd1);
      chk("b2b_lat2", cyc - t1, 3);
      a_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("b2b_mem0", {24'd0, mem[8'h10]}, 32'h11);
      chk("b2b_mem1", {24'd0, mem[8'h11]}, 32'h22);

      chk("both_done_cycles", both_cnt, 0);
      chk("a_done_total", a_cnt, exp_a);
      chk("b_done_total", b_cnt, exp_b);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
